// File: rtl/display_arbiter_if.sv
// Requester-side and display-side signals of the display arbiter.
// The arbiter connects through the slave modport. The requesters and the
// decoder side connect through the master modport.
interface display_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 8,
    parameter int unsigned SW   = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      disp_data;
    logic [SW-1:0]      disp_src;
    logic               busy;

    modport master (
        output req, req_data,
        input  grant, done, disp_data, disp_src, busy
    );

    modport slave (
        input  req, req_data,
        output grant, done, disp_data, disp_src, busy
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter for the shared seven-segment display path.
// The arbiter latches the byte of the granted requester and holds it for
// HOLD_TICKS divider ticks. It then releases the grant and pulses done to
// that requester. The last value stays on disp_data until the next grant.
module display_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DW         = 8,
    parameter int unsigned HOLD_TICKS = 16,
    parameter int unsigned CW         = 5,
    parameter int unsigned SW         = 2
) (
    input logic             clk,
    input logic             rstn,
    input logic             tick,
    display_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHOW    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [SW-1:0] LAST_IDX  = SW'(NREQ - 1);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   disp_data_q, disp_data_d;
    logic [SW-1:0]   disp_src_q, disp_src_d;
    logic            busy_q, busy_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;

    logic            pick_valid;
    logic [SW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic [DW-1:0]   pick_data;

    // Round-robin pick: the scan starts at rr_ptr and runs up to the top index,
    // then wraps from index 0 up to rr_ptr-1.
    always_comb begin
        pick_valid  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        pick_data   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_valid && (i >= 32'(rr_ptr_q)) && bus.req[i]) begin
                pick_valid     = 1'b1;
                pick_idx       = SW'(i);
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_data      = bus.req_data[i*DW +: DW];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!pick_valid && (i < 32'(rr_ptr_q)) && bus.req[i]) begin
                pick_valid     = 1'b1;
                pick_idx       = SW'(i);
                pick_onehot    = '0;
                pick_onehot[i] = 1'b1;
                pick_data      = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Next-state logic for grant, hold and release.
    // In SHOW, a dropped request has priority over a completing tick.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        disp_data_d = disp_data_q;
        disp_src_d  = disp_src_q;
        busy_d      = busy_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d     = ST_SHOW;
                    grant_d     = pick_onehot;
                    busy_d      = 1'b1;
                    disp_data_d = pick_data;
                    disp_src_d  = pick_idx;
                    hold_cnt_d  = '0;
                end
            end
            ST_SHOW: begin
                if (!bus.req[disp_src_q]) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_RELEASE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        done_d  = grant_q;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CW'(1);
                    end
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (disp_src_q == LAST_IDX) ? '0 : disp_src_q + SW'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. The asynchronous reset aborts a grant in progress
    // and does not issue done for it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            disp_data_q <= '0;
            disp_src_q  <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            disp_data_q <= disp_data_d;
            disp_src_q  <= disp_src_d;
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.disp_data = disp_data_q;
    assign bus.disp_src  = disp_src_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter with NREQ=4 and HOLD_TICKS=4.
// Tick pulses once every three clocks.
module tb_display_arbiter;

    localparam int HOLD = 4;

    logic clk;
    logic rstn;
    logic tick;
    logic tick_en;
    int   phase;
    int   total;
    int   bad;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];

    display_arbiter_if #(.NREQ(4), .DW(8), .SW(2)) bus ();

    display_arbiter #(
        .NREQ(4),
        .DW(8),
        .HOLD_TICKS(HOLD),
        .CW(3),
        .SW(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .tick(tick),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advances to 1 time unit after the next rising edge and updates tick.
    // The tick value set here is sampled at the following edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tick_en) begin
            phase = (phase == 2) ? 0 : phase + 1;
            tick  = (phase == 2);
        end else begin
            tick = 1'b0;
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        bus.req = '0;
        rstn    = 1'b0;
        cyc();
        cyc();
        rstn = 1'b1;
    endtask

    // Waits a bounded number of cycles for a grant.
    // It then checks the grant against the next scoreboard entry.
    task automatic wait_grant(input int exp_lat);
        exp_t       e;
        int         n;
        logic [3:0] oh;
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.grant == 4'b0000 && n < 40);
        total++;
        if (bus.grant == 4'b0000) begin
            bad++;
            $display("FAIL grant_timeout: grant=%b after %0d cycles, required a grant", bus.grant, n);
        end else if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL grant_unexpected: grant=%b, required none queued", bus.grant);
        end else begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.idx;
            if (bus.grant !== oh || bus.disp_data !== e.data ||
                bus.disp_src !== 2'(e.idx) || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL grant_value: grant=%b data=%h src=%0d busy=%b, required grant=%b data=%h src=%0d busy=1",
                         bus.grant, bus.disp_data, bus.disp_src, bus.busy, oh, e.data, e.idx);
            end
            if (exp_lat > 0) begin
                total++;
                if (n != exp_lat) begin
                    bad++;
                    $display("FAIL grant_latency: %0d cycles, required %0d", n, exp_lat);
                end
            end
        end
    endtask

    // Counts the ticks the DUT samples while the grant is held.
    // Grant and data must stay stable until HOLD ticks are counted. Done must
    // then pulse. In cycle chg_cycle, data2 is changed to 8'h22.
    task automatic wait_hold(input logic [3:0] exp_grant, input logic [7:0] exp_data, input int chg_cycle);
        int   cnt;
        int   n;
        logic t;
        cnt = 0;
        n   = 0;
        while (cnt < HOLD && n < 200) begin
            t = tick;
            cyc();
            n++;
            if (n == chg_cycle) bus.req_data[23:16] = 8'h22;
            if (t) cnt++;
            total++;
            if (cnt < HOLD) begin
                if (bus.grant !== exp_grant || bus.done !== 4'b0000 || bus.disp_data !== exp_data) begin
                    bad++;
                    $display("FAIL hold_show: grant=%b done=%b data=%h, required grant=%b done=0000 data=%h",
                             bus.grant, bus.done, bus.disp_data, exp_grant, exp_data);
                end
            end else begin
                if (bus.grant !== 4'b0000 || bus.done !== exp_grant || bus.busy !== 1'b0 ||
                    bus.disp_data !== exp_data) begin
                    bad++;
                    $display("FAIL hold_done: grant=%b done=%b busy=%b data=%h, required grant=0000 done=%b busy=0 data=%h",
                             bus.grant, bus.done, bus.busy, bus.disp_data, exp_grant, exp_data);
                end
            end
        end
        if (cnt < HOLD) begin
            total++;
            bad++;
            $display("FAIL hold_timeout: counted %0d ticks, required %0d", cnt, HOLD);
        end
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        cyc();
        cyc();
        total++;
        if (bus.grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_grant: %b, required 0000", bus.grant);
        end
        total++;
        if (bus.done !== 4'b0000) begin
            bad++;
            $display("FAIL reset_done: %b, required 0000", bus.done);
        end
        total++;
        if (bus.disp_data !== 8'h00 || bus.disp_src !== 2'd0) begin
            bad++;
            $display("FAIL reset_disp: data=%h src=%0d, required 00/0", bus.disp_data, bus.disp_src);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: %b, required 0", bus.busy);
        end
        rstn = 1'b1;
        push_exp(0, 8'hA0);
        wait_grant(1);
        bus.req = 4'b0000;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_single_hold();
        apply_reset();
        bus.req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.req      = 4'b0100;
        push_exp(2, 8'hA5);
        wait_grant(1);
        wait_hold(4'b0100, 8'hA5, -1);
        bus.req = 4'b0000;
        cyc();
        total++;
        if (bus.done !== 4'b0000) begin
            bad++;
            $display("FAIL single_done_width: done=%b, required 0000", bus.done);
        end
        cyc();
        cyc();
        total++;
        if (bus.disp_data !== 8'hA5 || bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
            bad++;
            $display("FAIL single_retain: data=%h busy=%b grant=%b, required A5/0/0000",
                     bus.disp_data, bus.busy, bus.grant);
        end
    endtask

    task automatic test_round_robin();
        int         order[5];
        logic [7:0] dat[4];
        order = '{0, 1, 3, 0, 1};
        dat   = '{8'h10, 8'h21, 8'h32, 8'h43};
        apply_reset();
        bus.req_data = {dat[3], dat[2], dat[1], dat[0]};
        bus.req      = 4'b1011;
        for (int k = 0; k < 5; k++) push_exp(order[k], dat[order[k]]);
        for (int k = 0; k < 5; k++) begin
            wait_grant(k == 0 ? 1 : 2);
            wait_hold(4'b0001 << order[k], dat[order[k]], -1);
        end
        bus.req = 4'b0000;
        cyc();
        cyc();
    endtask

    task automatic test_data_freeze();
        apply_reset();
        bus.req_data = {8'h44, 8'h11, 8'h02, 8'h01};
        bus.req      = 4'b0100;
        push_exp(2, 8'h11);
        push_exp(2, 8'h22);
        wait_grant(1);
        wait_hold(4'b0100, 8'h11, 3);
        wait_grant(2);
        bus.req = 4'b0000;
        cyc();
        cyc();
        cyc();
    endtask

    // A request drops in the same cycle as the tick that would complete the
    // hold. The grant must then release without done. rr_ptr must move to 2.
    task automatic test_abort();
        int   cnt;
        int   n;
        logic t;
        apply_reset();
        bus.req_data = {8'h44, 8'h33, 8'h77, 8'h55};
        bus.req      = 4'b0010;
        push_exp(1, 8'h77);
        wait_grant(1);
        cnt = 0;
        n   = 0;
        while (cnt < HOLD - 1 && n < 100) begin
            t = tick;
            cyc();
            n++;
            if (t) cnt++;
        end
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        bus.req = 4'b0101;
        push_exp(2, 8'h33);
        cyc();
        total++;
        if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_release: grant=%b done=%b busy=%b, required 0000/0000/0",
                     bus.grant, bus.done, bus.busy);
        end
        cyc();
        total++;
        if (bus.done !== 4'b0000) begin
            bad++;
            $display("FAIL abort_no_done: done=%b, required 0000", bus.done);
        end
        wait_grant(1);
        bus.req = 4'b0000;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.req_data = {8'h44, 8'h33, 8'hE1, 8'hE0};
        bus.req      = 4'b0011;
        push_exp(0, 8'hE0);
        push_exp(1, 8'hE1);
        wait_grant(1);
        wait_hold(4'b0001, 8'hE0, -1);
        wait_grant(2);
        cyc();
        #3;
        rstn = 1'b0;
        #1;
        total++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.disp_data !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: grant=%b busy=%b data=%h, required 0000/0/00",
                     bus.grant, bus.busy, bus.disp_data);
        end
        cyc();
        total++;
        if (bus.done !== 4'b0000) begin
            bad++;
            $display("FAIL async_reset_done: done=%b, required 0000", bus.done);
        end
        rstn = 1'b1;
        push_exp(0, 8'hE0);
        wait_grant(1);
        bus.req = 4'b0000;
        cyc();
        cyc();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        phase        = 0;
        tick         = 1'b0;
        tick_en      = 1'b1;
        rstn         = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        test_reset();
        test_single_hold();
        test_round_robin();
        test_data_freeze();
        test_abort();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
